// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
//   Shared constants for the wide sequential magnitude comparator.
//   - FSM state encoding: ST_IDLE, ST_CMP and ST_DONE. ST_DONE is the last state.
//   - Result encoding: one-hot {gt, eq, lt} flags. RES_NONE means no result yet.
//   - Helper function that packs the nibble comparator outputs into a result
//     code.
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit order matches the output flags: {a_gt_b, a_eq_b, a_lt_b}.
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // A nibble that is not equal is either greater or less.
    function automatic logic [2:0] nibble_result(input logic gt);
        return gt ? RES_GT : RES_LT;
    endfunction

endpackage

// File: rtl/cmp_nibble.sv
// -----------------------------------------------------------------------------
// cmp_nibble
//   Purely combinational unsigned comparison of two 4-bit values.
//   Ports:
//     a_i, b_i : 4-bit operands
//     gt       : a_i > b_i
//     eq       : a_i == b_i
//     lt       : a_i < b_i
// -----------------------------------------------------------------------------
module cmp_nibble (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a_i > b_i);
    assign eq = (a_i == b_i);
    assign lt = (a_i < b_i);

endmodule

// File: rtl/wide_cmp_seq.sv
// -----------------------------------------------------------------------------
// wide_cmp_seq
//   Multi-cycle magnitude comparator for WIDTH-bit operands.
//   A single 4-bit nibble comparator is stepped from the most significant
//   nibble down to the least significant one, at one nibble per clock. The
//   scan stops at the first nibble that differs. Both the input side and the
//   result side use a valid/ready handshake.
//
//   Parameters:
//     WIDTH : operand width. Must be a multiple of 4 and at least 4.
//
//   Ports:
//     clk, rst    : clock and synchronous active-high reset
//     in_valid    : input handshake, operands valid
//     in_ready    : input handshake, high only when the block is idle
//     a_i, b_i    : operands, sampled only when the input handshake completes
//     out_valid   : result valid, held until out_ready
//     out_ready   : result accepted; only takes effect in DONE
//     a_gt_b, a_eq_b, a_lt_b : one-hot result flags. They hold until the next
//                              accept.
//     cycles_o    : number of nibble steps used (1..NIB)
//     signed_i    : present only with SIGNED_CMP_EN. When set at accept, the
//                   compare is two's complement.
//
//   Build option:
//     SIGNED_CMP_EN : adds the signed_i port. When signed_i is set, the MSB of
//                     both operands is inverted as they are latched, which
//                     turns the unsigned scan into a signed compare.
// -----------------------------------------------------------------------------
module wide_cmp_seq
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int NIB   = WIDTH / 4,
    localparam int CW    = $clog2(NIB + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
`ifdef SIGNED_CMP_EN
    input  logic             signed_i,
`endif
    output logic [CW-1:0]    cycles_o
);

    // Width of the nibble index. It is at least one bit, so that the
    // single-nibble case still has a legal register.
    localparam int IW   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int NSLT = 1 << IW;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("wide_cmp_seq: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [2:0]       res_q, res_d;
    logic [CW-1:0]    cyc_q, cyc_d;

    // Mask applied to both operands at latch time. Inverting the sign bit
    // maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] flip_mask;
`ifdef SIGNED_CMP_EN
    assign flip_mask = {signed_i, {(WIDTH-1){1'b0}}};
`else
    assign flip_mask = '0;
`endif

    // Split the operands into nibble slots. The table is padded to a power
    // of two, so that every value of idx_q selects a defined entry.
    logic [3:0] a_nibs [NSLT];
    logic [3:0] b_nibs [NSLT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLT; gi++) begin : g_nib
            if (gi < NIB) begin : g_used
                assign a_nibs[gi] = a_q[4*gi +: 4];
                assign b_nibs[gi] = b_q[4*gi +: 4];
            end else begin : g_pad
                assign a_nibs[gi] = 4'h0;
                assign b_nibs[gi] = 4'h0;
            end
        end
    endgenerate

    logic [3:0] a_nib, b_nib;
    logic       nib_gt, nib_eq, nib_lt;

    assign a_nib = a_nibs[idx_q];
    assign b_nib = b_nibs[idx_q];

    cmp_nibble u_cmp_nibble (
        .a_i (a_nib),
        .b_i (b_nib),
        .gt  (nib_gt),
        .eq  (nib_eq),
        .lt  (nib_lt)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        res_d     = res_q;
        cyc_d     = cyc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a_i ^ flip_mask;
                    b_d     = b_i ^ flip_mask;
                    idx_d   = IW'(NIB - 1);
                    res_d   = RES_NONE;
                    cyc_d   = '0;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (nib_gt || nib_lt) begin
                    res_d   = nibble_result(nib_gt);
                    cyc_d   = CW'(NIB) - CW'(idx_q);
                    state_d = ST_DONE;
                end else if (nib_eq && idx_q == '0) begin
                    res_d   = RES_EQ;
                    cyc_d   = CW'(NIB);
                    state_d = ST_DONE;
                end else begin
                    // Equal nibble with more nibbles left below it.
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= RES_NONE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            cyc_q   <= cyc_d;
        end
    end

    assign a_gt_b   = res_q[2];
    assign a_eq_b   = res_q[1];
    assign a_lt_b   = res_q[0];
    assign cycles_o = cyc_q;

endmodule

// File: tb/tb_wide_cmp_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_cmp_seq
//   Directed tests for wide_cmp_seq with WIDTH=32. A reference model predicts
//   each result from the whole operands: the flags come from the full-width
//   compare, and the step count comes from the position of the first
//   differing nibble. The model is checked against the DUT on every cycle.
//   Each directed operation also checks the hand-computed flags, step count
//   and latency.
// -----------------------------------------------------------------------------
module tb_wide_cmp_seq;

    localparam int WIDTH = 32;
    localparam int NIB   = 8;
    localparam int CW    = 4;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a_i, b_i;
    logic              out_valid;
    logic              out_ready;
    logic              a_gt_b, a_eq_b, a_lt_b;
    logic [CW-1:0]     cycles_o;
    logic              sgn_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wide_cmp_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .a_lt_b    (a_lt_b),
`ifdef SIGNED_CMP_EN
        .signed_i  (sgn_in),
`endif
        .cycles_o  (cycles_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;

    mstate_t    m_st = M_IDLE;
    int         m_rem = 0;
    logic [2:0] m_res = 3'b000;
    int         m_cyc = 0;
    logic [2:0] m_pend_res = 3'b000;
    int         m_pend_cyc = 0;
    bit         started = 1'b0;

    // The result comes from a full-width compare. The number of steps is the
    // position, counted from the top, of the first nibble that differs, or
    // NIB when all nibbles are equal.
    function automatic void predict(input logic [31:0] a, input logic [31:0] b,
                                    input logic sgn, output logic [2:0] res, output int k);
        bit found = 1'b0;
        k = NIB;
        for (int i = NIB - 1; i >= 0; i--) begin
            if (!found && (((a >> (4*i)) & 32'hF) != ((b >> (4*i)) & 32'hF))) begin
                k = NIB - i;
                found = 1'b1;
            end
        end
        if (sgn) begin
            res = ($signed(a) > $signed(b)) ? GT : (($signed(a) < $signed(b)) ? LT : EQ);
        end else begin
            res = (a > b) ? GT : ((a < b) ? LT : EQ);
        end
    endfunction

    always @(posedge clk) begin : model
        logic [2:0] r;
        int         k;
        started <= 1'b1;
        if (rst) begin
            m_st  <= M_IDLE;
            m_res <= 3'b000;
            m_cyc <= 0;
        end else begin
            case (m_st)
                M_IDLE: if (in_valid) begin
                    predict(a_i, b_i, sgn_in, r, k);
                    m_pend_res <= r;
                    m_pend_cyc <= k;
                    m_rem      <= k;
                    m_st       <= M_BUSY;
                end
                M_BUSY: begin
                    if (m_rem == 1) begin
                        m_st  <= M_DONE;
                        m_res <= m_pend_res;
                        m_cyc <= m_pend_cyc;
                    end else begin
                        m_rem <= m_rem - 1;
                    end
                end
                M_DONE: if (out_ready) m_st <= M_IDLE;
                default: m_st <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model. The flags are not defined
    // while a compare is still in progress, so they are not checked then.
    always @(negedge clk) begin
        if (started) begin
            check("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_st == M_IDLE});
            check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_st == M_DONE});
            if (m_st != M_BUSY) begin
                check("cyc_flags", {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, m_res});
                check("cyc_cycles", {28'd0, cycles_o}, m_cyc);
            end
        end
    end

    // ---------------- directed operation ----------------
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [2:0] exp_res, input int exp_k,
                          input int hold, input bit pulse, input bit rdy_early);
        int lat;
        @(negedge clk);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a_i = a; b_i = b; sgn_in = sgn; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a_i = $urandom; b_i = $urandom; sgn_in = 1'b0;
        if (rdy_early) out_ready = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (out_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid not seen within %0d cycles, required within %0d", name, lat, exp_k + 1);
        end else begin
            check({name, "_latency"}, lat, exp_k + 1);
            check({name, "_flags"}, {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, exp_res});
            check({name, "_cycles"}, {28'd0, cycles_o}, exp_k);
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = ~in_valid;
                a_i = $urandom; b_i = $urandom;
            end
            @(negedge clk);
            check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, "_hold_flags"}, {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, exp_res});
        end
        // Release the result. With pulse set, in_valid is held high during the
        // release cycle, to show that it is not accepted in that same cycle.
        in_valid = pulse;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check({name, "_release_ready"}, {31'd0, in_ready}, 32'd1);
        check({name, "_release_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_release_flags"}, {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, exp_res});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; sgn_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("por_in_ready", {31'd0, in_ready}, 32'd1);
        check("por_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;

        // Reset in the middle of a compare. The operands differ only in the
        // LSB nibble, so the scan would still be running.
        @(negedge clk);
        a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFE; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_flags", {29'd0, a_gt_b, a_eq_b, a_lt_b}, 32'd0);
        check("rst_cycles", {28'd0, cycles_o}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_no_stale", {31'd0, out_valid}, 32'd0);

        run_op("msb_gt",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, GT, 1, 0, 1'b0, 1'b0);
        run_op("full_eq",  32'h1234_5678, 32'h1234_5678, 1'b0, EQ, 8, 0, 1'b0, 1'b0);
        run_op("lsb_lt",   32'h0000_0003, 32'h0000_0004, 1'b0, LT, 8, 0, 1'b0, 1'b1);
        run_op("mid_lt",   32'h1230_0000, 32'h1240_0000, 1'b0, LT, 3, 1, 1'b0, 1'b0);
        run_op("zero_eq",  32'h0000_0000, 32'h0000_0000, 1'b0, EQ, 8, 0, 1'b0, 1'b0);
        run_op("max_gt",   32'hFFFF_FFFF, 32'h0000_0000, 1'b0, GT, 1, 0, 1'b0, 1'b0);
        run_op("bp_gt",    32'hABCD_0000, 32'hABCC_FFFF, 1'b0, GT, 4, 5, 1'b1, 1'b0);
        run_op("uns_m1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, GT, 1, 0, 1'b0, 1'b0);
`ifdef SIGNED_CMP_EN
        run_op("sgn_m1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, LT, 1, 0, 1'b0, 1'b0);
        run_op("sgn_min",  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, LT, 1, 0, 1'b0, 1'b0);
        run_op("sgn_eq",   32'h8765_4321, 32'h8765_4321, 1'b1, EQ, 8, 0, 1'b0, 1'b0);
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
